// File: rtl/msk_pipe_reg_pkg.sv
// Shared layout helpers for masked gadgets: sharing width and per-share slice position.
// Share j of a sharing occupies bits [j*count +: count].
`ifndef MSK_SHARE
`define MSK_SHARE(j, cnt) [(j)*(cnt) +: (cnt)]
`endif

package msk_pipe_reg_pkg;

  localparam int unsigned MSK_D_DEFAULT     = 2;
  localparam int unsigned MSK_COUNT_DEFAULT = 1;

  function automatic int unsigned msk_width(input int unsigned d, input int unsigned count);
    return d * count;
  endfunction

  function automatic int unsigned msk_share_lsb(input int unsigned j, input int unsigned count);
    return j * count;
  endfunction

endpackage

// File: rtl/msk_pipe_reg_if.sv
// Valid/ready channel carrying one whole sharing; master drives valid/data.
interface msk_pipe_reg_if #(
  parameter int unsigned W = 2
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/msk_pipe_stage.sv
// One elastic stage: valid flop plus enabled share-wise data register.
module msk_pipe_stage
  import msk_pipe_reg_pkg::*;
#(
  parameter int unsigned d     = MSK_D_DEFAULT,
  parameter int unsigned count = MSK_COUNT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_adv,
  input  logic                         i_up_valid,
  input  logic [msk_width(d,count)-1:0] i_up_data,
  output logic                         o_valid,
  output logic [msk_width(d,count)-1:0] o_data
);

  logic                          r_valid;
  logic [msk_width(d,count)-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_flush)
        r_valid <= 1'b0;
      else if (i_adv)
        r_valid <= i_up_valid;
      // Data loads only with a real upstream sharing, so empty slots never latch junk.
      if (i_adv && i_up_valid)
        r_data <= i_up_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/msk_pipe_reg.sv
// Elastic masked pipeline register: DEPTH handshaked stages, shares moved bit-for-bit.
module msk_pipe_reg
  import msk_pipe_reg_pkg::*;
#(
  parameter int unsigned d     = 2,
  parameter int unsigned count = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  msk_pipe_reg_if.slave  in,
  msk_pipe_reg_if.master out
);

  localparam int unsigned W = msk_width(d, count);

  if (DEPTH < 1) begin : g_depth_chk
    $error("msk_pipe_reg: DEPTH must be >= 1");
  end

  logic [DEPTH:0]   w_adv;
  logic [DEPTH-1:0] w_valid;
  logic [W-1:0]     w_data [DEPTH];
  logic             w_in_xfer;

  // Ready chain runs combinationally from the output back to the input.
  assign w_adv[DEPTH] = out.ready;
  assign in.ready     = w_adv[0] & ~flush;
  assign w_in_xfer    = in.valid & in.ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic         w_up_valid;
    logic [W-1:0] w_up_data;

    assign w_adv[k] = ~w_valid[k] | w_adv[k+1];

    if (k == 0) begin : g_head
      assign w_up_valid = w_in_xfer;
      assign w_up_data  = in.data;
    end else begin : g_body
      assign w_up_valid = w_valid[k-1];
      assign w_up_data  = w_data[k-1];
    end

    msk_pipe_stage #(
      .d     (d),
      .count (count)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_flush    (flush),
      .i_adv      (w_adv[k]),
      .i_up_valid (w_up_valid),
      .i_up_data  (w_up_data),
      .o_valid    (w_valid[k]),
      .o_data     (w_data[k])
    );
  end

  assign out.valid = w_valid[DEPTH-1];
  assign out.data  = w_data[DEPTH-1];

endmodule

// File: tb/tb_msk_pipe_reg.sv
// Directed bench: DUT A (d=2,count=8,DEPTH=3) for pipeline behaviour, DUT B (d=3,count=8,DEPTH=1) for share isolation.
module tb_msk_pipe_reg;

  logic clk = 1'b0;
  logic rst_n;
  logic a_flush;
  logic b_flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  msk_pipe_reg_if #(.W(16)) a_in  ();
  msk_pipe_reg_if #(.W(16)) a_out ();
  msk_pipe_reg_if #(.W(24)) b_in  ();
  msk_pipe_reg_if #(.W(24)) b_out ();

  msk_pipe_reg #(.d(2), .count(8), .DEPTH(3)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (a_flush),
    .in    (a_in),
    .out   (a_out)
  );

  msk_pipe_reg #(.d(3), .count(8), .DEPTH(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (b_flush),
    .in    (b_in),
    .out   (b_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs changed afterwards are stable for the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sd [4];
  logic [15:0] bp [4];
  logic [7:0]  s1;
  logic        m_v;
  logic [23:0] m_d;
  logic        rdy;

  initial begin
    sd[0] = 16'h3CA5; sd[1] = 16'hFF01; sd[2] = 16'h5A12; sd[3] = 16'h0F80;
    bp[0] = 16'h1111; bp[1] = 16'h2222; bp[2] = 16'h3333; bp[3] = 16'h4444;

    rst_n = 1'b0;
    a_flush = 1'b0; b_flush = 1'b0;
    a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(a_out.valid), 32'd0);
    chk("rst_out_data", 32'(a_out.data), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(a_in.ready), 32'd1);

    // Streaming, DEPTH-cycle latency, one sharing per cycle
    a_out.ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_in.valid = (i < 4);
      a_in.data  = (i < 4) ? sd[i] : 16'h0;
      if (i < 4) chk("stream_in_ready", 32'(a_in.ready), 32'd1);
      tick();
      chk("stream_out_valid", 32'(a_out.valid), 32'((i >= 2) && (i < 6)));
      if (i >= 2 && i < 6) chk("stream_out_data", 32'(a_out.data), 32'(sd[i-2]));
    end
    a_in.valid = 1'b0;

    // Back-pressure
    a_out.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in.valid = 1'b1; a_in.data = bp[i];
      #1 chk("bp_fill_in_ready", 32'(a_in.ready), 32'd1);
      tick();
    end
    a_in.data = bp[3];
    #1 chk("bp_full_in_ready", 32'(a_in.ready), 32'd0);
    chk("bp_full_out", 32'(a_out.data), 32'(bp[0]));
    tick();
    chk("bp_stall_out_valid", 32'(a_out.valid), 32'd1);
    chk("bp_stall_out", 32'(a_out.data), 32'(bp[0]));
    a_out.ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(a_in.ready), 32'd1);
    tick();
    a_out.ready = 1'b0; a_in.valid = 1'b0;
    #1 chk("bp_shift_out", 32'(a_out.data), 32'(bp[1]));
    chk("bp_shift_in_ready", 32'(a_in.ready), 32'd0);
    a_out.ready = 1'b1;
    tick(); chk("bp_drain0", 32'(a_out.data), 32'(bp[2]));
    tick(); chk("bp_drain1", 32'(a_out.data), 32'(bp[3]));
    tick(); chk("bp_drain_empty", 32'(a_out.valid), 32'd0);

    // Bubble collapse
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 16'hC0C0;
    tick();
    a_in.valid = 1'b0;
    tick(); tick();
    a_in.valid = 1'b1; a_in.data = 16'hC1C1;
    tick();
    a_in.valid = 1'b0;
    tick();
    chk("bub_out_valid", 32'(a_out.valid), 32'd1);
    chk("bub_out", 32'(a_out.data), 32'hC0C0);
    chk("bub_in_ready", 32'(a_in.ready), 32'd1);
    tick();
    chk("bub_hold_out", 32'(a_out.data), 32'hC0C0);
    chk("bub_hold_in_ready", 32'(a_in.ready), 32'd1);
    a_out.ready = 1'b1;
    tick(); chk("bub_drain1", 32'(a_out.data), 32'hC1C1);
    chk("bub_drain1_valid", 32'(a_out.valid), 32'd1);
    tick(); chk("bub_drain_empty", 32'(a_out.valid), 32'd0);

    // Flush with two items in flight and a competing input
    a_in.valid = 1'b1; a_in.data = 16'hF0F0;
    tick();
    a_in.data = 16'hF1F1;
    tick();
    a_in.data = 16'hF2F2; a_flush = 1'b1;
    #1 chk("flush_in_ready", 32'(a_in.ready), 32'd0);
    tick();
    a_flush = 1'b0; a_in.valid = 1'b0;
    chk("flush_out_valid", 32'(a_out.valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_stale", 32'(a_out.valid), 32'd0);
    end

    // Asynchronous reset mid-stream
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 16'hAB01;
    tick();
    a_in.data = 16'hAB02;
    tick();
    a_in.valid = 1'b0;
    tick();
    chk("rst_pre_out", 32'(a_out.data), 32'hAB01);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(a_out.valid), 32'd0);
    chk("rst_async_data", 32'(a_out.data), 32'h0);
    #2 rst_n = 1'b1;
    a_out.ready = 1'b1;
    a_in.valid = 1'b1; a_in.data = 16'h7E81;
    tick();
    a_in.valid = 1'b0;
    tick();
    chk("rst_lat_not_yet", 32'(a_out.valid), 32'd0);
    tick();
    chk("rst_lat_valid", 32'(a_out.valid), 32'd1);
    chk("rst_lat_data", 32'(a_out.data), 32'h7E81);

    // Share isolation on DUT B: only share 1 ever carries nonzero data
    m_v = 1'b0; m_d = '0;
    for (int i = 0; i < 24; i++) begin
      s1 = 8'($urandom_range(1, 255));
      b_in.valid  = 1'($urandom_range(0, 1));
      b_out.ready = 1'($urandom_range(0, 1));
      b_in.data   = {8'h00, s1, 8'h00};
      rdy = ~m_v | b_out.ready;
      #1 chk("iso_in_ready", 32'(b_in.ready), 32'(rdy));
      if (rdy) begin
        if (b_in.valid) m_d = {8'h00, s1, 8'h00};
        m_v = b_in.valid;
      end
      tick();
      chk("iso_share0", 32'(b_out.data[7:0]), 32'h0);
      chk("iso_share2", 32'(b_out.data[23:16]), 32'h0);
      chk("iso_valid", 32'(b_out.valid), 32'(m_v));
      chk("iso_data", 32'(b_out.data), 32'(m_d));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
